change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/ticket_counter_pkg.sv | 21 ++
 rtl/change_fifo.sv | 48 ++++
 rtl/change_dispenser.sv | 170 +++++++++++++++++
 tb/tb_change_dispenser.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_counter_pkg.sv
// Shared definitions for the change dispenser and vending machine:
// change codes and the dispenser FSM state encoding.
package ticket_counter_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_50   = 2'b01;
  localparam logic [1:0] CHG_100  = 2'b10;
  localparam logic [1:0] CHG_150  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    DRIVE100,
    WAIT100,
    DRIVE50,
    WAIT50,
    DONE,
    FAULT
  } disp_state_e;

endpackage

// File: rtl/change_fifo.sv
// Synchronous FIFO of change requests; an extra pointer bit tells full from empty.
module change_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/change_dispenser.sv
// Queues change requests and drives the 100/50 JPY hoppers one coin at a time,
// re-pulsing on a missing exit-sensor pulse and faulting after repeated misses.
module change_dispenser
  import ticket_counter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_returned,
  input  logic [1:0] change_value,
  input  logic       coin_sensed,
  input  logic       fault_clear,
  output logic       hop100_pulse,
  output logic       hop50_pulse,
  output logic       busy,
  output logic       dispense_done,
  output logic       fault,
  output logic       overflow,
  output logic [2:0] pending
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0] RTY_ONE = RTY_W'(1);

  disp_state_e      state_q;
  logic [1:0]       code_q;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic [RTY_W-1:0] retry_q;
  logic             hop100_q;
  logic             hop50_q;
  logic             done_q;
  logic             fault_q;
  logic             overflow_q;

  logic             push_req;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             ovf_event;
  logic             timed_out;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_MAX) ? v : v + TMR_ONE;
  endfunction

  assign push_req  = change_returned && (change_value != CHG_NONE);
  assign fifo_pop  = (state_q == POP);
  assign ovf_event = push_req && fifo_full && !fifo_pop;
  assign tmr_d     = sat_inc(tmr_q);
  assign timed_out = (tmr_d == TMR_MAX);

  change_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (change_value),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= CHG_NONE;
      tmr_q      <= '0;
      retry_q    <= '0;
      hop100_q   <= 1'b0;
      hop50_q    <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hop100_q <= 1'b0;
      hop50_q  <= 1'b0;
      done_q   <= 1'b0;
      if (fault_clear) overflow_q <= 1'b0;
      if (ovf_event)   overflow_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= POP;
        end
        POP: begin
          code_q  <= fifo_head;
          retry_q <= '0;
          if (fifo_head[1]) begin
            state_q  <= DRIVE100;
            hop100_q <= 1'b1;
          end else begin
            state_q <= DRIVE50;
            hop50_q <= 1'b1;
          end
        end
        DRIVE100: begin
          state_q <= WAIT100;
          tmr_q   <= '0;
        end
        DRIVE50: begin
          state_q <= WAIT50;
          tmr_q   <= '0;
        end
        WAIT100, WAIT50: begin
          tmr_q <= tmr_d;
          if (coin_sensed) begin
            retry_q <= '0;
            // Only a 150 request still owes a 50 coin after the 100 coin.
            if (state_q == WAIT100 && code_q == CHG_150) begin
              state_q <= DRIVE50;
              hop50_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (timed_out) begin
            if (retry_q == RTY_MAX) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              retry_q <= retry_q + RTY_ONE;
              if (state_q == WAIT100) begin
                state_q  <= DRIVE100;
                hop100_q <= 1'b1;
              end else begin
                state_q <= DRIVE50;
                hop50_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        FAULT: begin
          if (fault_clear) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            retry_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hop100_pulse  = hop100_q;
  assign hop50_pulse   = hop50_q;
  assign dispense_done = done_q;
  assign fault         = fault_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign pending       = 3'(fifo_count);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of single requests plus hand-written
// timeout/fault, overflow, reset-abort and stray-coin sequences.
module tb_change_dispenser;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       change_returned;
  logic [1:0] change_value;
  logic       coin_sensed;
  logic       fault_clear;
  logic       hop100_pulse;
  logic       hop50_pulse;
  logic       busy;
  logic       dispense_done;
  logic       fault;
  logic       overflow;
  logic [2:0] pending;

  change_dispenser dut (
    .clk             (clk),
    .reset           (reset),
    .change_returned (change_returned),
    .change_value    (change_value),
    .coin_sensed     (coin_sensed),
    .fault_clear     (fault_clear),
    .hop100_pulse    (hop100_pulse),
    .hop50_pulse     (hop50_pulse),
    .busy            (busy),
    .dispense_done   (dispense_done),
    .fault           (fault),
    .overflow        (overflow),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int coin_cd  = 0;
  int n100, n50, ndone, first_hop;
  bit auto_coin;
  int t50[$];

  typedef struct {
    logic [1:0] code;
    int exp_pend;
    int exp_lat;
    int exp_100;
    int exp_50;
    int exp_done;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr_counts();
    n100 = 0; n50 = 0; ndone = 0; first_hop = -1;
    t50.delete();
  endtask

  // One clock: inputs applied before the call are sampled at this edge,
  // outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    change_returned = 1'b0;
    fault_clear     = 1'b0;
    coin_sensed     = 1'b0;
    if (coin_cd > 0) begin
      coin_cd--;
      if (coin_cd == 0) coin_sensed = 1'b1;
    end
    if (hop100_pulse) begin
      n100++;
      if (first_hop < 0) first_hop = cyc;
      if (auto_coin) coin_cd = 3;
    end
    if (hop50_pulse) begin
      n50++;
      t50.push_back(cyc);
      if (first_hop < 0) first_hop = cyc;
      if (auto_coin) coin_cd = 3;
    end
    if (dispense_done) ndone++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [1:0] code);
    change_returned = 1'b1;
    change_value    = code;
    tick();
  endtask

  initial begin
    int strobe_cyc;
    int lat;
    int d1, d2;

    vecs[0] = '{code: 2'b00, exp_pend: 0, exp_lat: -1, exp_100: 0, exp_50: 0, exp_done: 0};
    vecs[1] = '{code: 2'b01, exp_pend: 1, exp_lat: 2,  exp_100: 0, exp_50: 1, exp_done: 1};
    vecs[2] = '{code: 2'b10, exp_pend: 1, exp_lat: 2,  exp_100: 1, exp_50: 0, exp_done: 1};
    vecs[3] = '{code: 2'b11, exp_pend: 1, exp_lat: 2,  exp_100: 1, exp_50: 1, exp_done: 1};

    reset = 1'b1;
    change_returned = 1'b0;
    change_value = 2'b00;
    coin_sensed = 1'b0;
    fault_clear = 1'b0;
    auto_coin = 1'b0;
    clr_counts();
    ticks(2);
    check("rst_outputs", int'({hop100_pulse, hop50_pulse, busy, dispense_done, fault, overflow}), 0);
    check("rst_pending", int'(pending), 0);
    reset = 1'b0;
    ticks(2);

    for (int v = 0; v < 4; v++) begin
      clr_counts();
      auto_coin  = 1'b1;
      strobe_cyc = cyc + 1;
      strobe(vecs[v].code);
      check($sformatf("v%0d_pending_after_push", v), int'(pending), vecs[v].exp_pend);
      check($sformatf("v%0d_busy_after_push", v), int'(busy), (vecs[v].code != 2'b00) ? 1 : 0);
      ticks(30);
      lat = (first_hop >= 0) ? first_hop - strobe_cyc : -1;
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_hop100", v), n100, vecs[v].exp_100);
      check($sformatf("v%0d_hop50", v), n50, vecs[v].exp_50);
      check($sformatf("v%0d_done", v), ndone, vecs[v].exp_done);
      check($sformatf("v%0d_pending_end", v), int'(pending), 0);
      check($sformatf("v%0d_busy_end", v), int'(busy), 0);
    end

    // Missing coins: three hop50 pulses T+1 apart, then FAULT.
    clr_counts();
    auto_coin  = 1'b0;
    strobe_cyc = cyc + 1;
    strobe(2'b01);
    ticks(70);
    d1 = (t50.size() >= 3) ? t50[1] - t50[0] : -1;
    d2 = (t50.size() >= 3) ? t50[2] - t50[1] : -1;
    lat = (t50.size() >= 1) ? t50[0] - strobe_cyc : -1;
    check("to_hop50_count", n50, 3);
    check("to_first_latency", lat, 2);
    check("to_spacing1", d1, T + 1);
    check("to_spacing2", d2, T + 1);
    check("to_fault", int'(fault), 1);
    check("to_no_done", ndone, 0);

    // In FAULT: pushes accepted, no pulses; fault_clear resumes with queue intact.
    clr_counts();
    strobe(2'b10);
    ticks(5);
    check("flt_pending", int'(pending), 1);
    check("flt_no_pulses", n100 + n50, 0);
    check("flt_held", int'(fault), 1);
    auto_coin   = 1'b1;
    fault_clear = 1'b1;
    tick();
    check("flt_cleared", int'(fault), 0);
    ticks(30);
    check("flt_resume_hop100", n100, 1);
    check("flt_resume_done", ndone, 1);
    check("flt_resume_pending", int'(pending), 0);

    // Six back-to-back requests while the hopper is stalled.
    clr_counts();
    auto_coin = 1'b0;
    for (int i = 0; i < 6; i++) strobe(2'b10);
    check("ovf_pending", int'(pending), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_inflight", n100, 1);
    auto_coin   = 1'b1;
    coin_sensed = 1'b1;
    ticks(100);
    check("ovf_all_hop100", n100, 5);
    check("ovf_all_done", ndone, 5);
    check("ovf_pending_end", int'(pending), 0);
    check("ovf_sticky", int'(overflow), 1);
    fault_clear = 1'b1;
    tick();
    check("ovf_cleared", int'(overflow), 0);

    // Stray coin in IDLE.
    clr_counts();
    coin_sensed = 1'b1;
    tick();
    ticks(4);
    check("stray_busy", int'(busy), 0);
    check("stray_events", n100 + n50 + ndone, 0);

    // Reset while waiting on a 100 coin with two requests queued.
    clr_counts();
    auto_coin = 1'b0;
    for (int i = 0; i < 3; i++) strobe(2'b10);
    tick();
    check("rstm_pending_before", int'(pending), 2);
    check("rstm_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("rstm_outputs", int'({hop100_pulse, hop50_pulse, busy, dispense_done, fault, overflow}), 0);
    check("rstm_pending", int'(pending), 0);
    clr_counts();
    ticks(2);
    reset = 1'b0;
    coin_sensed = 1'b1;
    ticks(10);
    check("rstm_no_events", n100 + n50 + ndone, 0);
    check("rstm_pending_after", int'(pending), 0);
    check("rstm_busy_after", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
